// File: rtl/bus_fifo_bridge.sv
// Producer-to-CPU bridge: DEPTH-entry FIFO drained over a 4-phase sent/received
// handshake, with sticky overflow, occupancy count and CPU-side flush.
module bus_fifo_bridge #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNTW  = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] bus_input,
   input  logic             bus_input_valid,
   output logic             bus_received,
   output logic [WIDTH-1:0] bus_data,
   output logic             bus_sent,
   input  logic             cpu_received,
   input  logic             cpu_flush,
   output logic [CNTW-1:0]  fifo_count,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, PRESENT, WAIT_LOW} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic             full, push_ok, pop;

   assign full    = (fifo_count == CNTW'(DEPTH));
   assign push_ok = bus_input_valid && !full && !cpu_flush;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Flush suppresses the IDLE pop so an emptied FIFO is never read.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (fifo_count != '0 && !cpu_flush) state_nxt = PRESENT;
         PRESENT:  if (cpu_received)                   state_nxt = WAIT_LOW;
         WAIT_LOW: if (!cpu_received)                  state_nxt = IDLE;
         default:                                      state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pop      = (state == IDLE) && (fifo_count != '0) && !cpu_flush;
      bus_sent = (state == PRESENT);
   end

   always_ff @(posedge clk) begin
      if (!reset && push_ok) mem[wptr] <= bus_input;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr         <= '0;
         rptr         <= '0;
         fifo_count   <= '0;
         overflow     <= 1'b0;
         bus_received <= 1'b0;
         bus_data     <= '0;
      end else if (cpu_flush) begin
         wptr         <= '0;
         rptr         <= '0;
         fifo_count   <= '0;
         overflow     <= 1'b0;
         bus_received <= 1'b0;
      end else begin
         bus_received <= push_ok;
         if (push_ok) wptr <= wptr + AW'(1);
         if (bus_input_valid && full) overflow <= 1'b1;
         if (pop) begin
            bus_data <= mem[rptr];
            rptr     <= rptr + AW'(1);
         end
         fifo_count <= fifo_count + CNTW'(push_ok) - CNTW'(pop);
      end
   end

endmodule

// File: doc/bus_fifo_bridge.md
Name: bus_fifo_bridge

Overview:
- Parametrised successor of the single-word bus handshake block.
- Buffers producer words in a DEPTH-entry FIFO and presents them to the CPU over a 4-phase sent/received handshake.
- Adds an overflow flag, an occupancy count and a CPU flush.
- Sits between the external/peripheral byte source and the accumulator CPU's input port.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, FIFO entries; power of two, >=2
CNTW, $clog2(DEPTH)+1, width of the occupancy count

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
bus_input  in  WIDTH  producer data word
bus_input_valid  in  1  producer strobe; one word per cycle high
bus_received  out  1  push acknowledge to producer
bus_data  out  WIDTH  word presented to CPU
bus_sent  out  1  word-valid toward CPU
cpu_received  in  1  CPU acknowledge (4-phase)
cpu_flush  in  1  CPU request to empty FIFO and clear overflow
fifo_count  out  CNTW  current occupancy, 0..DEPTH
overflow  out  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- All state updates occur on the posedge of clk. Reset is synchronous and active-high and has priority over every other input.
- Reset values:
  - bus_data = 0, bus_sent = 0, bus_received = 0, fifo_count = 0, overflow = 0.
  - Read/write pointers = 0; FSM = IDLE.
- Push side:
  - When bus_input_valid=1 and the FIFO is not full (count before this edge < DEPTH), bus_input is written at wptr and wptr advances mod DEPTH.
  - bus_received is 1 for exactly the cycle after the accepted edge; otherwise it is 0.
  - When bus_input_valid=1 and the FIFO is full, the word is dropped, overflow is set to 1 and bus_received stays 0.
  - Simultaneous push and pop on a full FIFO: the push is rejected. Fullness is judged on the pre-edge count. The pop still happens.
- Pop/CPU side FSM, states IDLE, PRESENT, WAIT_LOW:
  - IDLE: if count>0, then bus_data <= mem[rptr], rptr advances, count decrements, bus_sent <= 1, go to PRESENT. Otherwise remain.
  - PRESENT: hold bus_data and bus_sent=1. When cpu_received=1 is sampled, bus_sent <= 0 and go to WAIT_LOW.
  - WAIT_LOW: when cpu_received=0 is sampled, go to IDLE. bus_data holds its last value.
  - cpu_received=1 in IDLE is ignored. A new word is never presented until cpu_received has returned low.
- Latency:
  - Push into an empty FIFO at edge t gives bus_sent=1 after edge t+1.
  - Back-to-back words are at minimum 2 cycles apart on bus_sent, when the CPU acknowledges and releases in consecutive cycles.
- Count rules:
  - fifo_count = pre-edge count + accepted push − pop; concurrent push and pop leave it unchanged.
  - The count never exceeds DEPTH and never underflows.
  - Pointers wrap mod DEPTH with no bubble.
- cpu_flush=1 (second priority after reset):
  - Pointers and count go to 0, overflow goes to 0, bus_received goes to 0, and any push that cycle is ignored.
  - The FSM state is not changed, so an in-flight handshake completes normally. bus_data and bus_sent are held.
- overflow clears only on reset or cpu_flush.
- Reset mid-handshake: bus_sent drops the next cycle and the FSM returns to IDLE regardless of cpu_received.

Test Plan:
- Reset, then push 0x3C once with CPU acknowledging promptly: bus_received=1 for 1 cycle, bus_sent=1 two edges after the push, bus_data=0x3C. With cpu_received 1→0, bus_sent drops and count returns to 0.
- DEPTH=4, CPU holds cpu_received=0, push 0x01..0x06 on consecutive cycles: 0x01 is presented. 0x02..0x05 are stored (count=4). 0x06 is dropped, overflow=1, and there is no bus_received for it.
- Drain the previous FIFO with the CPU toggling cpu_received: order observed on bus_data is 0x01,0x02,0x03,0x04,0x05; count ends at 0; overflow stays 1 until cpu_flush is pulsed, then 0.
- FIFO full (count=4) with a pop in the same cycle as bus_input_valid=1 (0xAA): 0xAA is rejected, overflow=1, count=3.
- Word 0x55 in PRESENT, cpu_flush=1 with 2 words queued: count=0 next cycle, bus_data still 0x55 and bus_sent still 1 until cpu_received=1. No further words are presented afterward.
- Assert reset during PRESENT with cpu_received=1: the next cycle has bus_sent=0, bus_data=0, count=0, FSM=IDLE. A subsequent push of 0x7E is presented normally.
